// File: rtl/ov5640_pkg.sv
// ============================================================================
// Module      : ov5640_pkg
// Description : Shared types and default timing constants for the OV5640
//               camera FIFO control path (write side and video side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ov5640_pkg;

    // Write-side sequencer states
    typedef enum logic [2:0] {
        RST_ASSERT = 3'd0,
        RST_WAIT   = 3'd1,
        IDLE       = 3'd2,
        ARM        = 3'd3,
        STREAM     = 3'd4,
        DROP       = 3'd5
    } fifo_state_e;

    // Default cycles the FIFO reset is held high
    localparam int DEF_RST_CYCLES  = 16;
    // Default settle cycles after FIFO reset release before busy is trusted
    localparam int DEF_WAIT_CYCLES = 8;

endpackage : ov5640_pkg

`default_nettype wire

// File: rtl/ov5640_vsync_edge.sv
// ============================================================================
// Module      : ov5640_vsync_edge
// Description : Polarity-aware frame-boundary detector. Registers vsync once
//               and flags the cycle in which vsync enters its active level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov5640_vsync_edge
    import ov5640_pkg::*;
#(
    parameter bit ACT_HIGH = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vsync_i,
    output logic boundary_o
);

    // Previous vsync sample; resets to the inactive level so that a frame
    // already in its active vsync phase at reset release is seen as a boundary.
    logic vsync_q;

    // Delay vsync by one cycle for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_q <= ~ACT_HIGH;
        end else begin
            vsync_q <= vsync_i;
        end
    end

    assign boundary_o = (vsync_i == ACT_HIGH) && (vsync_q != ACT_HIGH);

endmodule : ov5640_vsync_edge

`default_nettype wire

// File: rtl/ov5640_fifo_ctrl.sv
// ============================================================================
// Module      : ov5640_fifo_ctrl
// Description : Write-side sequencer for the camera-to-video CDC FIFO
//               (cam_clk domain). Resets/flushes the FIFO, admits pixels only
//               from a frame boundary so whole frames enter the FIFO, and on
//               overflow drops the rest of the frame and flushes.
//               Optional statistics: define OV5640_FIFO_CTRL_STATS_EN to build
//               the frame_cnt / drop_cnt counters (otherwise tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov5640_fifo_ctrl
    import ov5640_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int WAIT_CYCLES    = DEF_WAIT_CYCLES,
    parameter bit VSYNC_ACT_HIGH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             cam_clk,
    input  logic             cam_rst_n,
    input  logic             enable,
    input  logic             s_valid,
    input  logic             s_vsync,
    input  logic             fifo_full,
    input  logic             fifo_wr_rst_busy,
    output logic             fifo_rst,
    output logic             fifo_wr_en,
    output logic             streaming,
    output logic             frame_start,
    output logic             ovf_pulse,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    // One timer serves both the reset-hold and the post-reset settle phases
    localparam int TMR_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);

    fifo_state_e      state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             fifo_rst_q;
    logic             streaming_q;
    logic             frame_start_q;
    logic             ovf_q;

    logic             boundary;
    logic             ovf_hit;
    logic             frame_hit;

    ov5640_vsync_edge #(
        .ACT_HIGH (VSYNC_ACT_HIGH)
    ) u_vsync_edge (
        .clk_i      (cam_clk),
        .rst_ni     (cam_rst_n),
        .vsync_i    (s_vsync),
        .boundary_o (boundary)
    );

    // Overflow wins over a boundary in the same cycle
    assign ovf_hit   = (state_q == STREAM) && s_valid && fifo_full;
    // A frame is admitted on ARM->STREAM entry and on every boundary that
    // keeps the sequencer streaming
    assign frame_hit = enable && boundary &&
                       ((state_q == ARM) || ((state_q == STREAM) && !ovf_hit));

    // Sequencer state, timer and registered status outputs
    always_ff @(posedge cam_clk or negedge cam_rst_n) begin
        if (!cam_rst_n) begin
            state_q       <= RST_ASSERT;
            tmr_q         <= '0;
            fifo_rst_q    <= 1'b1;
            streaming_q   <= 1'b0;
            frame_start_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            frame_start_q <= frame_hit;
            ovf_q         <= ovf_hit;
            case (state_q)
                RST_ASSERT: begin
                    if (tmr_q == RST_LAST) begin
                        state_q    <= RST_WAIT;
                        fifo_rst_q <= 1'b0;
                        tmr_q      <= '0;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                RST_WAIT: begin
                    // Busy is only trusted once the settle time has elapsed
                    if (tmr_q != WAIT_LAST) begin
                        tmr_q <= tmr_q + 1'b1;
                    end else if (!fifo_wr_rst_busy) begin
                        state_q <= enable ? ARM : IDLE;
                    end
                end
                IDLE: begin
                    if (enable) begin
                        state_q <= ARM;
                    end
                end
                ARM: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (boundary) begin
                        state_q     <= STREAM;
                        streaming_q <= 1'b1;
                    end
                end
                STREAM: begin
                    // enable is only honoured at a boundary so frames complete
                    if (ovf_hit) begin
                        state_q     <= DROP;
                        streaming_q <= 1'b0;
                    end else if (boundary && !enable) begin
                        state_q     <= IDLE;
                        streaming_q <= 1'b0;
                    end
                end
                DROP: begin
                    if (boundary) begin
                        state_q    <= RST_ASSERT;
                        fifo_rst_q <= 1'b1;
                        tmr_q      <= '0;
                    end
                end
                default: begin
                    state_q     <= RST_ASSERT;
                    fifo_rst_q  <= 1'b1;
                    streaming_q <= 1'b0;
                    tmr_q       <= '0;
                end
            endcase
        end
    end

    assign fifo_rst    = fifo_rst_q;
    assign streaming   = streaming_q;
    assign frame_start = frame_start_q;
    assign ovf_pulse   = ovf_q;
    assign fifo_wr_en  = (state_q == STREAM) && s_valid && !fifo_full && !fifo_wr_rst_busy;

`ifdef OV5640_FIFO_CTRL_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // Free-running wrap-around frame and overflow counters
    always_ff @(posedge cam_clk or negedge cam_rst_n) begin
        if (!cam_rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (frame_hit) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (ovf_hit) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule : ov5640_fifo_ctrl

`default_nettype wire

// File: tb/tb_ov5640_fifo_ctrl.sv
// ============================================================================
// Module      : tb_ov5640_fifo_ctrl
// Description : Randomized self-checking bench for ov5640_fifo_ctrl. Drives an
//               active-high and an active-low vsync build from the same
//               stimulus and compares both against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov5640_fifo_ctrl;

    localparam int M_RST  = 16;
    localparam int M_WAIT = 8;

    // Model phases
    localparam int P_FLUSH  = 0;
    localparam int P_SETTLE = 1;
    localparam int P_IDLE   = 2;
    localparam int P_ARMED  = 3;
    localparam int P_LIVE   = 4;
    localparam int P_DROP   = 5;

    logic clk;
    logic rst_n;
    logic enable, s_valid, s_vsync, fifo_full, busy;
    logic s_vsync_n;

    logic        a_rst, a_wr, a_str, a_fs, a_ovf;
    logic [15:0] a_fc, a_dc;
    logic        b_rst, b_wr, b_str, b_fs, b_ovf;
    logic [15:0] b_fc, b_dc;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_phase;
    int          m_left;
    bit          m_prev;
    bit          m_fs, m_ovf;
    logic [15:0] m_frames, m_drops;

    bit hold_en;

    assign s_vsync_n = ~s_vsync;

    ov5640_fifo_ctrl #(
        .RST_CYCLES(M_RST), .WAIT_CYCLES(M_WAIT), .VSYNC_ACT_HIGH(1'b1), .CNT_W(16)
    ) dut_hi (
        .cam_clk(clk), .cam_rst_n(rst_n), .enable(enable), .s_valid(s_valid),
        .s_vsync(s_vsync), .fifo_full(fifo_full), .fifo_wr_rst_busy(busy),
        .fifo_rst(a_rst), .fifo_wr_en(a_wr), .streaming(a_str),
        .frame_start(a_fs), .ovf_pulse(a_ovf), .frame_cnt(a_fc), .drop_cnt(a_dc)
    );

    ov5640_fifo_ctrl #(
        .RST_CYCLES(M_RST), .WAIT_CYCLES(M_WAIT), .VSYNC_ACT_HIGH(1'b0), .CNT_W(16)
    ) dut_lo (
        .cam_clk(clk), .cam_rst_n(rst_n), .enable(enable), .s_valid(s_valid),
        .s_vsync(s_vsync_n), .fifo_full(fifo_full), .fifo_wr_rst_busy(busy),
        .fifo_rst(b_rst), .fifo_wr_en(b_wr), .streaming(b_str),
        .frame_start(b_fs), .ovf_pulse(b_ovf), .frame_cnt(b_fc), .drop_cnt(b_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_FLUSH;
        m_left   = M_RST;
        m_prev   = 1'b0;
        m_fs     = 1'b0;
        m_ovf    = 1'b0;
        m_frames = '0;
        m_drops  = '0;
    endtask

    // One clock edge of the frame-admission rules, using the current inputs
    task automatic model_step();
        bit act, rise;
        act    = (s_vsync == 1'b1);
        rise   = act && !m_prev;
        m_prev = act;
        m_fs   = 1'b0;
        m_ovf  = 1'b0;
        case (m_phase)
            P_FLUSH: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_SETTLE;
                    m_left  = M_WAIT;
                end
            end
            P_SETTLE: begin
                if (m_left > 1) m_left--;
                else if (!busy) m_phase = enable ? P_ARMED : P_IDLE;
            end
            P_IDLE: if (enable) m_phase = P_ARMED;
            P_ARMED: begin
                if (!enable) m_phase = P_IDLE;
                else if (rise) begin
                    m_phase = P_LIVE;
                    m_fs    = 1'b1;
                    m_frames++;
                end
            end
            P_LIVE: begin
                if (s_valid && fifo_full) begin
                    m_phase = P_DROP;
                    m_ovf   = 1'b1;
                    m_drops++;
                end else if (rise) begin
                    if (enable) begin
                        m_fs = 1'b1;
                        m_frames++;
                    end else begin
                        m_phase = P_IDLE;
                    end
                end
            end
            P_DROP: begin
                if (rise) begin
                    m_phase = P_FLUSH;
                    m_left  = M_RST;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_regs();
        logic [15:0] efc, edc;
`ifdef OV5640_FIFO_CTRL_STATS_EN
        efc = m_frames;
        edc = m_drops;
`else
        efc = '0;
        edc = '0;
`endif
        chk("fifo_rst_hi",  {31'd0, a_rst}, {31'd0, m_phase == P_FLUSH});
        chk("fifo_rst_lo",  {31'd0, b_rst}, {31'd0, m_phase == P_FLUSH});
        chk("streaming_hi", {31'd0, a_str}, {31'd0, m_phase == P_LIVE});
        chk("streaming_lo", {31'd0, b_str}, {31'd0, m_phase == P_LIVE});
        chk("frame_st_hi",  {31'd0, a_fs},  {31'd0, m_fs});
        chk("frame_st_lo",  {31'd0, b_fs},  {31'd0, m_fs});
        chk("ovf_hi",       {31'd0, a_ovf}, {31'd0, m_ovf});
        chk("ovf_lo",       {31'd0, b_ovf}, {31'd0, m_ovf});
        chk("frame_cnt_hi", {16'd0, a_fc},  {16'd0, efc});
        chk("frame_cnt_lo", {16'd0, b_fc},  {16'd0, efc});
        chk("drop_cnt_hi",  {16'd0, a_dc},  {16'd0, edc});
        chk("drop_cnt_lo",  {16'd0, b_dc},  {16'd0, edc});
    endtask

    task automatic drive_random();
        if (s_vsync) s_vsync = ($urandom_range(3) != 0);
        else         s_vsync = ($urandom_range(39) == 0);
        s_valid   = $urandom_range(1);
        fifo_full = ($urandom_range(119) == 0);
        busy      = ($urandom_range(59) == 0);
        if (!hold_en && $urandom_range(299) == 0) enable = ~enable;
        if (hold_en) enable = 1'b1;
    endtask

    // One full clock cycle: drive, check write enable, advance model, check regs
    task automatic cycle();
        bit exp_wr;
        @(negedge clk);
        drive_random();
        #1;
        exp_wr = (m_phase == P_LIVE) && s_valid && !fifo_full && !busy;
        chk("wr_en_hi", {31'd0, a_wr}, {31'd0, exp_wr});
        chk("wr_en_lo", {31'd0, b_wr}, {31'd0, exp_wr});
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    // Wait (bounded) for streaming, then hit the async reset mid-cycle
    task automatic stream_reset();
        int k;
        hold_en = 1'b1;
        k = 0;
        while (m_phase != P_LIVE && k < 3000) begin
            cycle();
            k++;
        end
        if (m_phase != P_LIVE) chk("reach_stream", 32'd0, 32'd1);
        hold_en = 1'b0;
        @(posedge clk);
        #2;
        s_valid   = 1'b1;
        fifo_full = 1'b0;
        busy      = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("arst_fifo_rst", {31'd0, a_rst}, 32'd1);
        chk("arst_wr_en",    {31'd0, a_wr},  32'd0);
        chk("arst_stream",   {31'd0, a_str}, 32'd0);
        chk("arst_fcnt",     {16'd0, a_fc},  32'd0);
        chk("arst_dcnt",     {16'd0, a_dc},  32'd0);
        chk("arst_fifo_lo",  {31'd0, b_rst}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        s_valid   = 1'b0;
        s_vsync   = 1'b0;
        fifo_full = 1'b0;
        busy      = 1'b1;
        hold_en   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_regs();
        #1;
        rst_n = 1'b1;
        // Busy held for the first cycles after release
        repeat (4) begin
            @(negedge clk);
            busy = 1'b1;
            s_valid = $urandom_range(1);
            #1;
            chk("pwr_wr_en", {31'd0, a_wr}, 32'd0);
            model_step();
            @(posedge clk);
            #1;
            check_regs();
        end
        repeat (2500) cycle();
        stream_reset();
        repeat (2000) cycle();
        stream_reset();
        repeat (1500) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ov5640_fifo_ctrl

`default_nettype wire
